// File: rtl/reqdriver_pkg.sv
// Shared types and constants for the reqdriver Wishbone initiator.
package reqdriver_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrAck,
    StGap,
    StRdReq,
    StRdAck
  } state_e;

  localparam logic        WALKER_ADDR = 1'b0;
  localparam int unsigned STATUS_W    = 4;

  // States in which a Wishbone cycle is open.
  function automatic logic is_bus_state(state_e s);
    return (s == StWrReq) || (s == StWrAck) || (s == StRdReq) || (s == StRdAck);
  endfunction

endpackage

// File: rtl/reqdriver_if.sv
// Wishbone pipelined-mode bus between reqdriver (master) and the LED-walker (slave).
interface reqdriver_if;
  logic        o_cyc;
  logic        o_stb;
  logic        o_we;
  logic        o_addr;
  logic [31:0] o_data;
  logic        i_stall;
  logic        i_ack;
  logic [31:0] i_data;

  modport master (
    output o_cyc, o_stb, o_we, o_addr, o_data,
    input  i_stall, i_ack, i_data
  );

  modport slave (
    input  o_cyc, o_stb, o_we, o_addr, o_data,
    output i_stall, i_ack, i_data
  );
endinterface

// File: rtl/reqdriver_timer.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module reqdriver_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reqdriver.sv
// Wishbone initiator: writes START_WORD to the LED-walker, polls status until idle.
// Optional ack watchdog enabled by defining REQDRIVER_TIMEOUT_EN.
module reqdriver
  import reqdriver_pkg::*;
#(
  parameter logic [31:0] START_WORD  = 32'h0000_0001,
  parameter int unsigned POLL_GAP    = 16,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_request,
  reqdriver_if.master         bus,
  output logic                o_busy,
  output logic                o_done,
  output logic [STATUS_W-1:0] o_status,
  output logic                o_err
);

  localparam int unsigned     GapW    = $clog2(POLL_GAP + 1);
  // GAP lasts exactly POLL_GAP cycles: the exit happens on the cycle the counter reads zero.
  localparam logic [GapW-1:0] GapLoad = GapW'(POLL_GAP - 1);

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic                gap_load, gap_zero;
  logic                ack_ok, wd_expire;
  logic                unused_data;

  assign unused_data = ^bus.i_data[31:STATUS_W];
  assign ack_ok      = bus.i_ack && ((state_q == StWrAck) || (state_q == StRdAck));
  assign gap_load    = (state_d == StGap) && (state_q != StGap);

  reqdriver_timer #(
    .Width (GapW)
  ) u_gap_timer (
    .clk_i      (i_clk),
    .rst_ni     (i_reset_n),
    .load_i     (gap_load),
    .load_val_i (GapLoad),
    .en_i       (state_q == StGap),
    .zero_o     (gap_zero)
  );

`ifdef REQDRIVER_TIMEOUT_EN
  localparam int unsigned    WdW    = $clog2(ACK_TIMEOUT + 1);
  // Expiry is seen on zero, so loading one less makes o_err land ACK_TIMEOUT cycles after issue.
  localparam logic [WdW-1:0] WdLoad = WdW'(ACK_TIMEOUT - 1);

  logic wd_load, wd_zero;

  assign wd_load = ((state_d == StWrReq) && (state_q != StWrReq)) ||
                   ((state_d == StRdReq) && (state_q != StRdReq));

  reqdriver_timer #(
    .Width (WdW)
  ) u_wd_timer (
    .clk_i      (i_clk),
    .rst_ni     (i_reset_n),
    .load_i     (wd_load),
    .load_val_i (WdLoad),
    .en_i       (is_bus_state(state_q)),
    .zero_o     (wd_zero)
  );

  assign wd_expire = wd_zero && is_bus_state(state_q) && !ack_ok;
`else
  logic unused_timeout;

  assign unused_timeout = ^32'(ACK_TIMEOUT);
  assign wd_expire      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    status_d = status_q;
    unique case (state_q)
      // done_q high means the machine has only just returned; that request is dropped.
      StIdle:  if (i_request && !done_q) state_d = StWrReq;
      StWrReq: if (!bus.i_stall) state_d = StWrAck;
      StWrAck: if (ack_ok) state_d = StGap;
      StGap:   if (gap_zero) state_d = StRdReq;
      StRdReq: if (!bus.i_stall) state_d = StRdAck;
      StRdAck: begin
        if (ack_ok) begin
          status_d = bus.i_data[STATUS_W-1:0];
          if (bus.i_data[STATUS_W-1:0] == '0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StGap;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (wd_expire) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      err_q    <= err_d;
      status_q <= status_d;
    end
  end

  // Bus outputs decode straight from state so an async reset clears them at once.
  assign bus.o_cyc  = is_bus_state(state_q);
  assign bus.o_stb  = (state_q == StWrReq) || (state_q == StRdReq);
  assign bus.o_we   = (state_q == StWrReq);
  assign bus.o_addr = WALKER_ADDR;
  assign bus.o_data = (state_q == StWrReq) ? START_WORD : 32'h0;
  assign o_busy     = (state_q != StIdle);
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_status   = status_q;

`ifdef FORMAL
  logic outstanding_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      outstanding_q <= 1'b0;
    end else if (bus.o_stb && !bus.i_stall) begin
      outstanding_q <= 1'b1;
    end else if (bus.i_ack || !bus.o_cyc) begin
      outstanding_q <= 1'b0;
    end
  end

  assert property (@(posedge i_clk) disable iff (!i_reset_n) bus.o_stb |-> bus.o_cyc);
  assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (bus.o_stb && bus.i_stall) |=> (!bus.o_stb ||
      ($stable(bus.o_we) && $stable(bus.o_addr) && $stable(bus.o_data))));
  assert property (@(posedge i_clk) disable iff (!i_reset_n) outstanding_q |-> !bus.o_stb);
`endif

endmodule

// File: tb/tb_reqdriver.sv
// Directed self-checking bench for reqdriver (table vectors plus multi-cycle sequences).
module tb_reqdriver;

  typedef struct {
    logic        req;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [3:0]  status;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       busy, done, err;
  logic [3:0] status;
  int         total = 0;
  int         bad = 0;

  reqdriver_if bus ();

  reqdriver #(
    .START_WORD  (32'h0000_0001),
    .POLL_GAP    (4),
    .ACK_TIMEOUT (64)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_request (req),
    .bus       (bus),
    .o_busy    (busy),
    .o_done    (done),
    .o_status  (status),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic a, input logic [31:0] d);
    req         = r;
    bus.i_stall = s;
    bus.i_ack   = a;
    bus.i_data  = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic a, input logic [31:0] d,
                              input logic c, input logic sb, input logic w, input logic [31:0] wd,
                              input logic b, input logic dn, input logic [3:0] st);
    vec_t v;
    v.req = r; v.stall = s; v.ack = a; v.rdata = d;
    v.cyc = c; v.stb = sb; v.we = w; v.wdata = wd;
    v.busy = b; v.done = dn; v.status = st;
    return v;
  endfunction

  vec_t vecs[23];

  initial begin
    // Full transaction with POLL_GAP=4: stalled write, spurious acks, two reads.
    vecs[0]  = mk(1, 0, 0, 32'h0,         0, 0, 0, 32'h0, 0, 0, 4'h0);
    vecs[1]  = mk(0, 1, 0, 32'h0,         1, 1, 1, 32'h1, 1, 0, 4'h0);
    vecs[2]  = mk(0, 0, 0, 32'h0,         1, 1, 1, 32'h1, 1, 0, 4'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0,         1, 0, 0, 32'h0, 1, 0, 4'h0);
    vecs[4]  = mk(0, 0, 1, 32'h0,         1, 0, 0, 32'h0, 1, 0, 4'h0);
    vecs[5]  = mk(0, 0, 0, 32'h0,         0, 0, 0, 32'h0, 1, 0, 4'h0);
    vecs[6]  = mk(0, 0, 1, 32'h5,         0, 0, 0, 32'h0, 1, 0, 4'h0);
    vecs[7]  = mk(0, 0, 0, 32'h0,         0, 0, 0, 32'h0, 1, 0, 4'h0);
    vecs[8]  = mk(0, 0, 0, 32'h0,         0, 0, 0, 32'h0, 1, 0, 4'h0);
    vecs[9]  = mk(0, 0, 0, 32'h0,         1, 1, 0, 32'h0, 1, 0, 4'h0);
    vecs[10] = mk(0, 0, 1, 32'hABCD_0003, 1, 0, 0, 32'h0, 1, 0, 4'h0);
    vecs[11] = mk(0, 0, 0, 32'h0,         0, 0, 0, 32'h0, 1, 0, 4'h3);
    vecs[12] = mk(0, 0, 0, 32'h0,         0, 0, 0, 32'h0, 1, 0, 4'h3);
    vecs[13] = mk(0, 0, 0, 32'h0,         0, 0, 0, 32'h0, 1, 0, 4'h3);
    vecs[14] = mk(0, 0, 0, 32'h0,         0, 0, 0, 32'h0, 1, 0, 4'h3);
    vecs[15] = mk(0, 0, 0, 32'h0,         1, 1, 0, 32'h0, 1, 0, 4'h3);
    vecs[16] = mk(1, 0, 0, 32'h0,         1, 0, 0, 32'h0, 1, 0, 4'h3);
    vecs[17] = mk(0, 0, 1, 32'hFFFF_FFF0, 1, 0, 0, 32'h0, 1, 0, 4'h3);
    vecs[18] = mk(1, 0, 0, 32'h0,         0, 0, 0, 32'h0, 0, 1, 4'h0);
    vecs[19] = mk(0, 0, 1, 32'h7,         0, 0, 0, 32'h0, 0, 0, 4'h0);
    vecs[20] = mk(1, 0, 0, 32'h0,         0, 0, 0, 32'h0, 0, 0, 4'h0);
    vecs[21] = mk(0, 0, 0, 32'h0,         1, 1, 1, 32'h1, 1, 0, 4'h0);
    vecs[22] = mk(0, 0, 0, 32'h0,         1, 0, 0, 32'h0, 1, 0, 4'h0);

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.o_cyc, bus.o_stb, bus.o_we, busy, done, err, status}, 10'h0);
    chk("reset_data", bus.o_data, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step();
      chk($sformatf("vec%0d_ctl", i), {bus.o_cyc, bus.o_stb, bus.o_we, busy, done, err, status},
          {vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].busy, vecs[i].done, 1'b0,
           vecs[i].status});
      chk($sformatf("vec%0d_data", i), bus.o_data, vecs[i].wdata);
      chk($sformatf("vec%0d_addr", i), {31'h0, bus.o_addr}, 32'h0);
      drive(vecs[i].req, vecs[i].stall, vecs[i].ack, vecs[i].rdata);
    end

    // Machine sits in WR_ACK; pull reset mid-cycle and look before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_now", {bus.o_cyc, bus.o_stb, busy, done, err}, 5'h0);
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    chk("after_rst_idle", {bus.o_cyc, bus.o_stb, busy, done, err, status}, 9'h0);

    // Write held off by seven stall cycles.
    begin
      int accepts = 0;
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) begin
        step();
        req = 1'b0;
        chk($sformatf("stall_hold%0d", i), {bus.o_cyc, bus.o_stb, bus.o_we, bus.o_data},
            {3'b111, 32'h1});
        bus.i_stall = (i < 7);
        if (bus.o_stb && bus.o_we && !bus.i_stall) accepts++;
      end
      bus.i_stall = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (bus.o_stb && bus.o_we) accepts++;
      end
      chk("stall_one_write", accepts, 1);
    end
    do_reset();

    // Walker model: 11-step walk advancing every 5 cycles, one-cycle ack, no stall.
    begin
      int   walk = 0, wcnt = 0, writes = 0, reads = 0, dones = 0, post = 0;
      int   last = 0, mono_bad = 0, after_zero = 0;
      logic pend = 1'b0, pend_rd = 1'b0, zero_seen = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      for (int n = 0; n < 600; n++) begin
        step();
        req = 1'b0;
        if (done) dones++;
        if (dones > 0) post++;
        if (post > 10) break;
        bus.i_ack  = pend;
        bus.i_data = pend_rd ? walk : 32'h0;
        if (pend && pend_rd) begin
          reads++;
          if (zero_seen) after_zero++;
          if (walk != 0 && walk < last) mono_bad++;
          if (walk == 0) zero_seen = 1'b1;
          last = walk;
        end
        pend    = bus.o_stb;
        pend_rd = bus.o_stb && !bus.o_we;
        if (bus.o_stb && bus.o_we) begin
          writes++;
          chk("walk_wdata", bus.o_data, 32'h1);
          walk = 1;
          wcnt = 0;
        end else if (walk != 0) begin
          wcnt++;
          if (wcnt == 5) begin
            wcnt = 0;
            walk = (walk == 11) ? 0 : walk + 1;
          end
        end
      end
      chk("walk_writes", writes, 1);
      chk("walk_dones", dones, 1);
      chk("walk_status", {28'h0, status}, 32'h0);
      chk("walk_idle", {busy, bus.o_cyc}, 2'b00);
      chk("walk_monotonic", mono_bad, 0);
      chk("walk_zero_last", {after_zero[30:0], zero_seen}, 32'h1);
      chk("walk_many_reads", (reads >= 3), 1);
    end
    do_reset();

    // Slave accepts the write but never acks.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    req = 1'b0;
    chk("to_stb_issue", {bus.o_cyc, bus.o_stb}, 2'b11);
`ifdef REQDRIVER_TIMEOUT_EN
    begin
      int errs = 0, err_at = -1;
      for (int k = 1; k <= 100; k++) begin
        step();
        if (err) begin
          errs++;
          if (err_at < 0) begin
            err_at = k;
            chk("to_cyc_drop", {bus.o_cyc, bus.o_stb, busy}, 3'b000);
          end
        end
      end
      chk("to_err_cycle", err_at, 64);
      chk("to_err_once", errs, 1);
    end
`else
    begin
      int errs = 0;
      for (int k = 0; k < 1000; k++) begin
        step();
        if (err) errs++;
      end
      chk("no_to_cyc_held", {bus.o_cyc, busy}, 2'b11);
      chk("no_to_err", errs, 0);
    end
`endif
    do_reset();
    step();
    chk("final_idle", {bus.o_cyc, busy, err}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
